// File: rtl/credit_stream_tx.sv
// rtl/credit_stream_tx.sv - credit-gated transmitter for a ready-less stream link
module credit_stream_tx #(
    parameter int D_WIDTH   = 6,
    parameter int CREDITS   = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [D_WIDTH-1:0]   tx_data,
    output logic                 tx_valid,
    input  logic                 tx_credit,
    output logic [CNT_WIDTH-1:0] credit_cnt,
    output logic                 link_idle,
    output logic                 credit_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CREDITS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic send;
    logic cr;

    // Ready and idle are decoded from registers only so the source never sees a path from tx_credit.
    always_comb begin
        s_ready   = (credit_cnt != '0);
        link_idle = (credit_cnt == CNT_FULL) && !tx_valid;
        send      = s_valid && s_ready;
        cr        = tx_credit && !rst;
    end

    // Link register: one strobe per accepted word, data held between words.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= send;
            if (send) begin
                tx_data <= s_data;
            end
        end
    end

    // Credit counter: spend on send, refund on credit, saturate and flag a surplus credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CNT_FULL;
            credit_err <= 1'b0;
        end else begin
            if (send && !cr) begin
                credit_cnt <= credit_cnt - CNT_ONE;
            end else if (!send && cr) begin
                if (credit_cnt == CNT_FULL) begin
                    credit_err <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/credit_stream_tx.md
Name: credit_stream_tx

Overview:
Transmitter end of the credit-return stream link. It accepts words from a local valid/ready source and forwards each word as a one-cycle pulse on a ready-less link. The link feeds a downstream flop FIFO that raises a one-cycle credit pulse per pop. The block holds a credit counter preset to the receiver FIFO depth and never sends without a credit, so the receiver can never overflow.

Parameters:
D_WIDTH, 6, data word width.
CREDITS, 4, initial credit count; must equal receiver FIFO depth (2**A_WIDTH of receiver); >= 1.
CNT_WIDTH, 3, credit counter width; must satisfy 2**CNT_WIDTH > CREDITS.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-high.
s_data  input  D_WIDTH  source data.
s_valid  input  1  source word available.
s_ready  output  1  block can accept a word this cycle.
tx_data  output  D_WIDTH  link data, registered.
tx_valid  output  1  link word strobe, registered, one cycle per word; no backpressure.
tx_credit  input  1  credit return pulse from receiver; one credit per cycle-high.
credit_cnt  output  CNT_WIDTH  current available credits, registered.
link_idle  output  1  all credits home and no word in flight on tx_valid.
credit_err  output  1  sticky: credit returned while counter already at CREDITS.

Behaviour:
- Reset (rst=1 at edge): credit_cnt=CREDITS, tx_valid=0, tx_data=0, credit_err=0. While rst=1, tx_credit is ignored.
- s_ready = (credit_cnt != 0), combinational from register only, with no path from s_valid or tx_credit. A returned credit is usable the cycle after it arrives.
- send = s_valid & s_ready. On send, tx_data<=s_data and tx_valid<=1 at the next edge, giving 1-cycle latency. Otherwise tx_valid<=0 and tx_data holds its last value.
- Back-to-back: one word per cycle while credits remain; tx_valid stays high across consecutive cycles with new data each cycle.
- Credit update each cycle, with cr = tx_credit & ~rst:
  - send & ~cr: cnt-1.
  - ~send & cr: cnt+1.
  - send & cr: cnt unchanged.
  - neither: unchanged.
- Underflow cannot occur, because send requires cnt != 0.
- Overflow: if cr & ~send & cnt==CREDITS, cnt stays at CREDITS (saturate) and credit_err<=1. credit_err stays set until rst.
- If send & cr & cnt==CREDITS, the net change is zero and this is legal: no error.
- link_idle = (credit_cnt==CREDITS) & ~tx_valid, combinational from registers.
- Invariant: credit_cnt + words in receiver + words in flight == CREDITS at all times.
- Reset mid-operation: the in-flight tx_valid is dropped, the counter returns to CREDITS, and credit_err clears. The receiver FIFO must be reset in the same cycle; this is a system requirement, not checked here.
- s_data is captured only on send; it is don't-care when s_valid=0.
- No combinational path from any input to tx_valid/tx_data/credit_cnt.

Test Plan:
- Reset then idle, CREDITS=4: after rst release, credit_cnt=4, s_ready=1, tx_valid=0, link_idle=1, credit_err=0.
- Burst without credits: s_valid held high with data 0x01..0x06 and tx_credit=0. Four tx_valid pulses carry 0x01..0x04 on consecutive cycles, each 1 cycle after acceptance. credit_cnt goes 4,3,2,1,0. s_ready=0 once the count reaches 0, and 0x05 is held at the source.
- Credit resume: at cnt=0, pulse tx_credit for one cycle. Next cycle cnt=1 and s_ready=1; 0x05 is accepted and appears on tx_data one cycle later; cnt returns to 0.
- Simultaneous send + credit, cnt=2: s_valid=1 and tx_credit=1 in the same cycle. cnt stays at 2 and tx_valid pulses the word.
- Overflow: at cnt=4 with s_valid=0, pulse tx_credit. cnt stays at 4 and credit_err=1 and remains set; a later rst clears it.
- Loopback against the 4-deep credit-return FIFO receiver: random s_valid and random receiver pop for 1000 words. Data arrives in order, the receiver never drops a word, credit_err=0 throughout, and link_idle=1 after drain.
